// File: rtl/rom_load_sequencer_pkg.sv
// Shared ROM download constants: ioctl indexes, TMNT region map and sequencer state encoding.
package rom_load_sequencer_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;

  // TMNT map: program ROM in SDRAM, tile/sprite/sound ROMs in BRAM.
  localparam int                          TMNT_NREG     = 4;
  localparam logic [TMNT_NREG*ADDR_W-1:0] TMNT_BOUNDS   = {25'h100000, 25'h0C0000, 25'h080000, 25'h040000};
  localparam logic [TMNT_NREG-1:0]        TMNT_SDR_MASK = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_SDRW
  } seq_state_t;

endpackage

// File: rtl/rom_load_sequencer_region_decode.sv
// Combinational address decode: lowest region whose exclusive end exceeds the address.
// Zero latency; o_hit clears when the address lies past the last bound.
module rom_region_decode
  import rom_load_sequencer_pkg::*;
#(
  parameter int                     NREG   = 4,
  parameter logic [NREG*ADDR_W-1:0] BOUNDS = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NREG-1:0]   o_sel,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_hit
);

  logic [ADDR_W-1:0] w_lo;
  logic              w_found;

  always_comb begin
    o_sel   = '0;
    o_base  = '0;
    w_found = 1'b0;
    w_lo    = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!w_found && (i_addr < BOUNDS[i*ADDR_W +: ADDR_W])) begin
        w_found  = 1'b1;
        o_sel[i] = 1'b1;
        o_base   = w_lo;
      end
      w_lo = BOUNDS[i*ADDR_W +: ADDR_W];
    end
  end

  assign o_hit = w_found;

endmodule

// File: rtl/rom_load_sequencer.sv
// HPS ioctl word -> region-relative load strobe; load_we one cycle after an accepted ioctl_wr.
// Registered ioctl_wait stalls the HPS until the BRAM gap expires or the SDRAM ack arrives.
module rom_load_sequencer
  import rom_load_sequencer_pkg::*;
#(
  parameter int                     NREG      = 4,
  parameter logic [NREG*ADDR_W-1:0] BOUNDS    = '0,
  parameter logic [NREG-1:0]        SDR_MASK  = NREG'(1),
  parameter int                     BR_GAP    = 3,
  parameter logic [7:0]             ROM_INDEX = 8'd0
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              load_we,
  output logic [NREG-1:0]   load_sel,
  output logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] load_data,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic              load_done,
  output logic              err_oob,
  output logic              err_ovr
);

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_active_q;
  logic              r_wait;
  logic              r_we;
  logic              r_req;
  logic              r_done;
  logic              r_done_pend;
  logic              r_err_oob;
  logic              r_err_ovr;
  logic [NREG-1:0]   r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_data;

  logic              w_active;
  logic              w_rise;
  logic              w_fall;
  logic              w_wr;
  logic [NREG-1:0]   w_sel;
  logic [ADDR_W-1:0] w_base;
  logic              w_hit;

  assign w_active = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_rise   = w_active && !r_active_q;
  assign w_fall   = !w_active && r_active_q;
  assign w_wr     = ioctl_wr && w_active;

  rom_region_decode #(
    .NREG   (NREG),
    .BOUNDS (BOUNDS)
  ) u_decode (
    .i_addr (ioctl_addr),
    .o_sel  (w_sel),
    .o_base (w_base),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_active_q  <= 1'b0;
      r_wait      <= 1'b0;
      r_we        <= 1'b0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
      r_err_oob   <= 1'b0;
      r_err_ovr   <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_base      <= '0;
      r_data      <= '0;
    end else begin
      r_active_q <= w_active;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      if (w_rise) begin
        r_err_oob <= 1'b0;
        r_err_ovr <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_done_pend) begin
            r_done      <= 1'b1;
            r_done_pend <= 1'b0;
          end
          if (w_wr) begin
            if (w_hit) begin
              r_sel   <= w_sel;
              r_addr  <= ioctl_addr;
              r_base  <= w_base;
              r_data  <= ioctl_dout;
              r_we    <= 1'b1;
              r_wait  <= 1'b1;
              r_cnt   <= CNT_W'(BR_GAP - 1);
              r_state <= ST_ISSUE;
            end else begin
              r_err_oob <= 1'b1;
            end
          end
        end
        // The issue cycle counts toward the BRAM gap, giving BR_GAP+1 accept spacing.
        ST_ISSUE: begin
          if (|(r_sel & SDR_MASK)) begin
            r_req   <= 1'b1;
            r_state <= ST_SDRW;
          end else if (r_cnt == '0) begin
            r_wait  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_wait  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SDRW: begin
          if (sdr_ack) begin
            r_req   <= 1'b0;
            r_wait  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_wr && (r_state != ST_IDLE)) begin
        r_err_ovr <= 1'b1;
      end
      if (w_fall) begin
        r_done_pend <= 1'b1;
      end
    end
  end

  assign ioctl_wait = r_wait;
  assign load_we    = r_we;
  assign load_sel   = r_sel;
  assign load_addr  = r_addr - r_base;
  assign load_data  = r_data;
  assign sdr_req    = r_req;
  assign load_done  = r_done;
  assign err_oob    = r_err_oob;
  assign err_ovr    = r_err_ovr;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed and randomized checks of rom_load_sequencer against a region-map reference model.
`timescale 1ns/1ps
module tb_rom_load_sequencer;

  localparam int         BR_GAP = 3;
  localparam logic [3:0] SDR    = 4'b0001;

  int unsigned bnd [4] = '{32'h40000, 32'h80000, 32'hC0000, 32'h100000};

  logic        clk = 1'b0;
  logic        nRESET, ioctl_download, ioctl_wr, sdr_ack;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait, load_we, sdr_req, load_done, err_oob, err_ovr;
  logic [3:0]  load_sel;
  logic [24:0] load_addr;
  logic [15:0] load_data;

  int checks = 0, failures = 0, we_cnt = 0, done_cnt = 0;
  logic [44:0] obs_q[$];
  logic [44:0] exp_q[$];

  rom_load_sequencer #(
    .NREG      (4),
    .BOUNDS    ({25'h100000, 25'h0C0000, 25'h080000, 25'h040000}),
    .SDR_MASK  (SDR),
    .BR_GAP    (BR_GAP),
    .ROM_INDEX (8'd0)
  ) dut (
    .clk            (clk),
    .nRESET         (nRESET),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .load_we        (load_we),
    .load_sel       (load_sel),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .sdr_req        (sdr_req),
    .sdr_ack        (sdr_ack),
    .load_done      (load_done),
    .err_oob        (err_oob),
    .err_ovr        (err_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (load_we) begin
      we_cnt++;
      obs_q.push_back({load_sel, load_addr, load_data});
    end
    if (load_done) done_cnt++;
  end

  function automatic int region_of(input logic [24:0] a);
    for (int i = 0; i < 4; i++) if (32'(a) < bnd[i]) return i;
    return -1;
  endfunction

  function automatic logic [44:0] expect_strobe(input logic [24:0] a, input logic [15:0] d);
    int          r;
    logic [31:0] lo;
    r  = region_of(a);
    lo = 0;
    if (r > 0) lo = bnd[r-1];
    return {4'(1 << r), 25'(32'(a) - lo), d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [24:0] a, input logic [15:0] d);
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && ioctl_wait; i++) @(negedge clk);
    check(tag, ioctl_wait, 0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !sdr_req; i++) @(negedge clk);
    check(tag, sdr_req, 1);
  endtask

  initial begin
    int          n, base_we, base_done, r;
    logic        exp_oob;
    logic [24:0] a;
    logic [15:0] d;

    nRESET = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; sdr_ack = 1'b0;
    idle(3);
    check("rst_wait", ioctl_wait, 0);
    check("rst_we", load_we, 0);
    check("rst_sel", load_sel, 0);
    check("rst_addr_data", {load_addr, load_data}, 0);
    check("rst_req_done", {sdr_req, load_done}, 0);
    check("rst_errs", {err_oob, err_ovr}, 0);
    nRESET = 1'b1; ioctl_download = 1'b1;
    idle(2);

    // BRAM word into region 1
    base_we = we_cnt;
    send_word(25'h040010, 16'hBEEF);
    check("bram_we", load_we, 1);
    check("bram_sel", load_sel, 4'b0010);
    check("bram_addr", load_addr, 25'h10);
    check("bram_data", load_data, 16'hBEEF);
    check("bram_wait", ioctl_wait, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ioctl_wait) break;
      n++;
    end
    check("bram_wait_cycles", n, BR_GAP);
    check("bram_one_strobe", we_cnt - base_we, 1);
    check("bram_sel_hold", load_sel, 4'b0010);

    // SDRAM word into region 0, ack after 7 cycles of req
    base_we = we_cnt;
    send_word(25'h000100, 16'h1234);
    check("sdr_we", load_we, 1);
    check("sdr_sel", load_sel, 4'b0001);
    check("sdr_addr", load_addr, 25'h100);
    check("sdr_req_issue", sdr_req, 0);
    wait_req("sdr_req_rise");
    n = 1;
    repeat (6) begin
      @(negedge clk);
      if (sdr_req) n++;
    end
    check("sdr_wait_before_ack", ioctl_wait, 1);
    sdr_ack = 1'b1; @(negedge clk); sdr_ack = 1'b0;
    check("sdr_req_cycles", n, 7);
    check("sdr_req_drop", sdr_req, 0);
    check("sdr_wait_drop", ioctl_wait, 0);
    check("sdr_one_strobe", we_cnt - base_we, 1);

    base_we = we_cnt;
    sdr_ack = 1'b1; @(negedge clk); sdr_ack = 1'b0;
    idle(2);
    check("stray_ack_req", sdr_req, 0);
    check("stray_ack_we", we_cnt - base_we, 0);

    // Back-to-back BRAM words at the minimum 4-cycle spacing
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      a = 25'h080000 + 25'(k * 64);
      d = 16'hA000 + 16'(k);
      exp_q.push_back(expect_strobe(a, d));
      send_word(a, d);
      idle(2);
    end
    wait_idle("b2b_idle");
    check("b2b_ovr", err_ovr, 0);
    check("b2b_count", obs_q.size(), 4);
    for (int k = 0; k < exp_q.size(); k++) check("b2b_word", obs_q[k], exp_q[k]);

    // 2-cycle spacing: second word dropped
    base_we = we_cnt;
    send_word(25'h0C0000, 16'h1111);
    send_word(25'h0C0002, 16'h2222);
    check("ovr_set", err_ovr, 1);
    wait_idle("ovr_idle");
    check("ovr_dropped", we_cnt - base_we, 1);
    check("ovr_kept_data", load_data, 16'h1111);

    // Out of range, then cleared by the next download start
    base_we = we_cnt;
    send_word(25'h100000, 16'h5555);
    check("oob_we", load_we, 0);
    check("oob_wait", ioctl_wait, 0);
    check("oob_flag", err_oob, 1);
    idle(2);
    check("oob_no_strobe", we_cnt - base_we, 0);
    base_done = done_cnt;
    ioctl_download = 1'b0;
    idle(4);
    check("idle_end_done", done_cnt - base_done, 1);
    check("oob_sticky", err_oob, 1);
    ioctl_download = 1'b1;
    idle(1);
    check("oob_clear", err_oob, 0);
    check("ovr_clear", err_ovr, 0);

    // Download ends while an SDRAM write is pending
    send_word(25'h000200, 16'hCAFE);
    wait_req("end_req_rise");
    ioctl_download = 1'b0;
    base_done = done_cnt;
    idle(5);
    check("end_no_early_done", done_cnt - base_done, 0);
    check("end_req_held", sdr_req, 1);
    sdr_ack = 1'b1; @(negedge clk); sdr_ack = 1'b0;
    check("end_idle_cycle_done", load_done, 0);
    @(negedge clk);
    check("end_done_pulse", load_done, 1);
    @(negedge clk);
    check("end_done_low", load_done, 0);
    check("end_done_once", done_cnt - base_done, 1);

    // Foreign index is ignored entirely
    ioctl_index = 8'd4; ioctl_download = 1'b1;
    base_we = we_cnt; base_done = done_cnt;
    send_word(25'h040000, 16'h0BAD);
    check("idx_wait", ioctl_wait, 0);
    send_word(25'h100000, 16'h0BAD);
    check("idx_oob", err_oob, 0);
    ioctl_download = 1'b0;
    idle(3);
    check("idx_no_strobe", we_cnt - base_we, 0);
    check("idx_no_done", done_cnt - base_done, 0);

    // Reset during the BRAM gap
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    idle(1);
    base_we = we_cnt;
    send_word(25'h090000, 16'h7777);
    @(negedge clk);
    check("gap_wait", ioctl_wait, 1);
    nRESET = 1'b0;
    #1;
    check("rst_gap_outs", {ioctl_wait, load_we, load_sel, load_addr, load_data,
                           sdr_req, load_done, err_oob, err_ovr}, 0);
    idle(3);
    check("rst_gap_one_strobe", we_cnt - base_we, 1);
    nRESET = 1'b1;
    idle(2);

    // Randomized well-behaved HPS traffic against the region-map model
    obs_q.delete(); exp_q.delete(); exp_oob = 1'b0;
    for (int k = 0; k < 30; k++) begin
      a = 25'($urandom_range(0, 4) * 32'h40000 + 2 * $urandom_range(0, 32'h1FFFF));
      d = 16'($urandom);
      r = region_of(a);
      if (r < 0) exp_oob = 1'b1;
      else exp_q.push_back(expect_strobe(a, d));
      idle($urandom_range(0, 2));
      send_word(a, d);
      if (r >= 0 && SDR[r]) begin
        wait_req("rnd_req");
        idle($urandom_range(0, 7));
        sdr_ack = 1'b1; @(negedge clk); sdr_ack = 1'b0;
      end
      wait_idle("rnd_idle");
    end
    idle(2);
    check("rnd_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) check("rnd_strobe", obs_q[k], exp_q[k]);
    check("rnd_oob", err_oob, exp_oob);
    check("rnd_ovr", err_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
